// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences one 9-bit instruction at a time through an
// external ALU, with a 4x4 register file and host load/debug ports.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   instr_valid/instr instruction {op, rd, ra, rb}; instr_ready in IDLE
//   ld_en/ld_addr/ld_data  host register-file write (IDLE only)
//   dbg_addr/dbg_data combinational register-file read
//   alu_A/alu_B/alu_opcode registered operands to the external ALU
//   alu_result/alu_remainder/alu_zero/alu_overflow  ALU outputs
//   done/flag_zero/flag_ovf/div_err  completion pulse and status
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [8:0] instr,
  output logic       instr_ready,
  input  logic       ld_en,
  input  logic [1:0] ld_addr,
  input  logic [3:0] ld_data,
  input  logic [1:0] dbg_addr,
  output logic [3:0] dbg_data,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [2:0] alu_opcode,
  input  logic [3:0] alu_result,
  input  logic [3:0] alu_remainder,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       done,
  output logic       flag_zero,
  output logic       flag_ovf,
  output logic       div_err
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    WB,
    WB2
  } state_t;

  localparam logic [2:0] OP_DIV = 3'b111;

  state_t state_q;
  state_t state_d;

  logic [3:0] rf [4];

  logic [2:0] ir_op;
  logic [1:0] ir_rd;
  logic [1:0] ir_ra;
  logic [1:0] ir_rb;

  logic [3:0] cap_result;
  logic [3:0] cap_rem;
  logic       cap_zero;
  logic       cap_ovf;
  logic       div_zero_q;

  logic       accept;
  logic       is_div;
  logic       div_fault;
  logic [1:0] rd_next;

  assign is_div    = (ir_op == OP_DIV);
  // divide by zero is decided from the divisor seen in ISSUE
  assign div_fault = is_div && div_zero_q;
  assign rd_next   = ir_rd + 2'd1;
  assign accept    = instr_valid && instr_ready;
  assign dbg_data  = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = !reset;
        if (accept) state_d = ISSUE;
      end
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = WB;
      WB: begin
        // a good divide defers done to WB2
        if (is_div && !div_fault) begin
          state_d = WB2;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WB2: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
      ir_op      <= 3'd0;
      ir_rd      <= 2'd0;
      ir_ra      <= 2'd0;
      ir_rb      <= 2'd0;
      alu_A      <= 4'd0;
      alu_B      <= 4'd0;
      alu_opcode <= 3'd0;
      cap_result <= 4'd0;
      cap_rem    <= 4'd0;
      cap_zero   <= 1'b0;
      cap_ovf    <= 1'b0;
      div_zero_q <= 1'b0;
      flag_zero  <= 1'b0;
      flag_ovf   <= 1'b0;
      div_err    <= 1'b0;
    end else begin
      if (accept) begin
        ir_op   <= instr[8:6];
        ir_rd   <= instr[5:4];
        ir_ra   <= instr[3:2];
        ir_rb   <= instr[1:0];
        div_err <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          // a load in the accept cycle lands before ISSUE reads it
          if (ld_en) rf[ld_addr] <= ld_data;
        end
        ISSUE: begin
          alu_A      <= rf[ir_ra];
          alu_B      <= rf[ir_rb];
          alu_opcode <= ir_op;
          div_zero_q <= (rf[ir_rb] == 4'd0);
        end
        CAPTURE: begin
          cap_result <= alu_result;
          cap_rem    <= alu_remainder;
          cap_zero   <= alu_zero;
          cap_ovf    <= alu_overflow;
        end
        WB: begin
          if (div_fault) begin
            div_err <= 1'b1;
          end else begin
            rf[ir_rd] <= cap_result;
            flag_zero <= cap_zero;
            flag_ovf  <= cap_ovf;
          end
        end
        WB2: rf[rd_next] <= cap_rem;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random + directed checks of alu_sequencer
// against an instruction-level model of the register file and flags.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       instr_valid = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready;
  logic       ld_en = 1'b0;
  logic [1:0] ld_addr = '0;
  logic [3:0] ld_data = '0;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;
  logic [3:0] alu_A;
  logic [3:0] alu_B;
  logic [2:0] alu_opcode;
  logic [3:0] alu_result;
  logic [3:0] alu_remainder;
  logic       alu_zero;
  logic       alu_overflow;
  logic       done;
  logic       flag_zero;
  logic       flag_ovf;
  logic       div_err;

  int n_cmp = 0;
  int n_bad = 0;
  int m_rf [4];
  int m_fz, m_fo, m_de;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .alu_remainder(alu_remainder),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .done(done), .flag_zero(flag_zero), .flag_ovf(flag_ovf),
    .div_err(div_err)
  );

  always #5 clk = ~clk;

  // external ALU attached to the sequencer
  function automatic logic [9:0] alu_fn(logic [3:0] a, logic [3:0] b,
                                        logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r, q;
    logic o;
    r = '0; q = '0; o = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; o = s[4]; end
      3'd1: begin r = a - b; o = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[2:0], 1'b0}; o = a[3]; end
      3'd6: r = ~a;
      default: if (b != 0) begin r = a / b; q = a % b; end
    endcase
    return {o, (r == 4'd0), q, r};
  endfunction

  always_comb
    {alu_overflow, alu_zero, alu_remainder, alu_result} =
      alu_fn(alu_A, alu_B, alu_opcode);

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // instruction-level reference: returns the edge on which done is seen
  task automatic model_exec(int op, int rd, int ra, int rb,
                            output int exp_done);
    int a, b, r, q, o;
    a = m_rf[ra]; b = m_rf[rb]; r = 0; q = 0; o = 0;
    m_de = 0;
    if (op == 7 && b == 0) begin
      m_de = 1;
      exp_done = 3;
      return;
    end
    case (op)
      0: begin r = a + b; o = (r > 15); end
      1: begin r = a - b; o = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a * 2; o = (r > 15); end
      6: r = 15 - a;
      default: begin r = a / b; q = a % b; end
    endcase
    r = r & 15;
    m_rf[rd] = r;
    m_fz = (r == 0);
    m_fo = o;
    if (op == 7) begin
      m_rf[(rd + 1) % 4] = q;
      exp_done = 4;
    end else begin
      exp_done = 3;
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      chk($sformatf("R%0d", i), dbg_data, m_rf[i]);
    end
    chk("flag_zero", flag_zero, m_fz);
    chk("flag_ovf", flag_ovf, m_fo);
    chk("div_err", div_err, m_de);
  endtask

  task automatic load(int a, int d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a[1:0]; ld_data = d[3:0];
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic run(int op, int rd, int ra, int rb,
                     int ald = 0, int ala = 0, int ald_d = 0,
                     int bld = 0, int bla = 0, int bld_d = 0);
    int exp_done, first, cnt, ea, eb;
    @(negedge clk);
    chk("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {op[2:0], rd[1:0], ra[1:0], rb[1:0]};
    if (ald != 0) begin
      ld_en = 1'b1; ld_addr = ala[1:0]; ld_data = ald_d[3:0];
      m_rf[ala] = ald_d;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    ld_en = 1'b0;
    ea = m_rf[ra];
    eb = m_rf[rb];
    model_exec(op, rd, ra, rb, exp_done);
    // a load while busy must be ignored
    if (bld != 0) begin
      ld_en = 1'b1; ld_addr = bla[1:0]; ld_data = bld_d[3:0];
    end
    first = 0;
    cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (first == 0) first = e;
      end
      if (e == 2) begin
        chk("alu_A", alu_A, ea);
        chk("alu_B", alu_B, eb);
        chk("alu_opcode", alu_opcode, op);
      end
      if (e == exp_done) chk("ready_busy", instr_ready, 0);
      if (e == exp_done + 1) chk("ready_after", instr_ready, 1);
      @(posedge clk); #1;
      ld_en = 1'b0;
    end
    chk("done_cycle", first, exp_done);
    chk("done_count", cnt, 1);
    check_state();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    m_fz = 0; m_fo = 0; m_de = 0;
  endtask

  initial begin
    int op, rd, ra, rb, cnt;
    model_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("ready_in_reset", instr_ready, 0);
    chk("done_in_reset", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_post_reset", instr_ready, 1);
    chk("alu_A_reset", alu_A, 0);
    chk("alu_B_reset", alu_B, 0);
    chk("alu_op_reset", alu_opcode, 0);
    check_state();

    load(0, 5); load(1, 3);
    run(0, 2, 0, 1);

    load(0, 9); load(1, 9);
    run(0, 3, 0, 1);
    run(1, 0, 1, 1);

    load(2, 13); load(3, 4);
    run(7, 3, 2, 3);

    load(1, 0);
    run(7, 2, 0, 1);
    run(2, 0, 0, 0);

    run(3, 0, 0, 0, 0, 0, 0, 1, 0, 15);
    run(3, 2, 1, 0, 1, 1, 7);

    // reset while in CAPTURE aborts the instruction
    load(0, 6); load(1, 0);
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {3'b000, 2'd1, 2'd0, 2'd0};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("ready_mid_reset", instr_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("ready_after_abort", instr_ready, 1);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) cnt++;
      @(negedge clk);
    end
    chk("done_after_abort", cnt, 0);
    check_state();

    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1)
          load($urandom_range(0, 3), $urandom_range(0, 15));
      op = ($urandom_range(0, 3) == 0) ? 7 : $urandom_range(0, 7);
      rd = $urandom_range(0, 3);
      ra = $urandom_range(0, 3);
      rb = $urandom_range(0, 3);
      if (op == 7 && $urandom_range(0, 3) == 0) load(rb, 0);
      if ($urandom_range(0, 4) == 0)
        run(op, rd, ra, rb, 1, $urandom_range(0, 3),
            $urandom_range(0, 15));
      else
        run(op, rd, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have port: reset  input  1  synchronous, active-high reset, sampled on clk rising edge.
REQ-003 The block SHALL have port: instr_valid  input  1  host presents an instruction.
REQ-004 The block SHALL have port: instr  input  9  {op[8:6], rd[5:4], ra[3:2], rb[1:0]}.
REQ-005 The block SHALL have port: instr_ready  output  1  block can accept an instruction.
REQ-006 The block SHALL have ports: ld_en  input  1, ld_addr  input  2, ld_data  input  4  host register-file write.
REQ-007 The block SHALL have ports: dbg_addr  input  2, dbg_data  output  4  combinational register-file read.
REQ-008 The block SHALL have ports: alu_A  output  4, alu_B  output  4, alu_opcode  output  3  registered operands/opcode to the ALU.
REQ-009 The block SHALL have ports: alu_result  input  4, alu_remainder  input  4, alu_zero  input  1, alu_overflow  input  1  ALU outputs.
REQ-010 The block SHALL have ports: done  output  1, flag_zero  output  1, flag_ovf  output  1, div_err  output  1  completion pulse and status.

Function
REQ-011 The block SHALL hold a 4-entry x 4-bit register file R0..R3.
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPTURE, WB, WB2.
REQ-013 instr_ready SHALL be 1 only in IDLE; an instruction is accepted when instr_valid && instr_ready, latching instr and moving to ISSUE.
REQ-014 ISSUE SHALL drive alu_A=R[ra], alu_B=R[rb], alu_opcode=op (registered, visible the cycle after ISSUE), then go to CAPTURE.
REQ-015 CAPTURE SHALL register alu_result, alu_remainder, alu_zero, alu_overflow, then go to WB.
REQ-016 WB SHALL write the captured result to R[rd], update flag_zero and flag_ovf from the captured flags, and pulse done for one cycle.
REQ-017 For op=3'b111 WB SHALL additionally go to WB2, which writes the captured remainder to R[(rd+1) mod 4] (wrap R3->R0); done SHALL pulse in WB2 instead of WB.
REQ-018 For op=3'b111 with R[rb]==0 (sampled in ISSUE), no register write SHALL occur, div_err SHALL be set to 1, flag_zero/flag_ovf SHALL be left unchanged, and done SHALL pulse in WB; FSM returns to IDLE.
REQ-019 div_err SHALL clear on the next accepted instruction.
REQ-020 Latency: accept edge at cycle 0 -> done at cycle 3 (cycle 4 for successful divide); instr_ready returns high the cycle after done.
REQ-021 ld_en SHALL write ld_data to R[ld_addr] only in IDLE; ld_en outside IDLE SHALL be ignored.
REQ-022 ld_en and an instruction accept in the same IDLE cycle SHALL both take effect; the instruction SHALL read the newly loaded value.
REQ-023 dbg_data SHALL equal R[dbg_addr] combinationally, reflecting writes the cycle after they occur.
REQ-024 alu_A, alu_B, alu_opcode SHALL hold their last values outside ISSUE.
REQ-025 Opcodes 000..110 SHALL never write R[(rd+1) mod 4].

Reset
REQ-026 reset SHALL force state IDLE, R0..R3=0, alu_A=alu_B=0, alu_opcode=0, done=0, flag_zero=0, flag_ovf=0, div_err=0, captured registers=0.
REQ-027 reset asserted mid-operation SHALL abort it with no register write and no done pulse; instr_ready SHALL be 0 during reset and 1 the cycle after reset deasserts.

Verification
REQ-028 Load R0=5, R1=3; instr op=000 rd=2 ra=0 rb=1 -> done at cycle 3, R2=8, flag_zero=0, flag_ovf=0.
REQ-029 Load R0=9, R1=9; op=000 rd=3 -> R3=2, flag_ovf=1 (carry-out); then op=001 ra=1 rb=1 rd=0 -> R0=0, flag_zero=1.
REQ-030 Load R2=13, R3=4; op=111 rd=3 ra=2 rb=3 -> R3=3, R0=1 (wrap), done at cycle 4 only.
REQ-031 Load R1=0; op=111 rb=1 rd=2 -> div_err=1, R2 and R3 unchanged, done at cycle 3; next accepted instruction clears div_err.
REQ-032 Assert reset in CAPTURE of op=000 rd=1 -> R1 stays 0, no done pulse, instr_ready=1 one cycle after reset release.
REQ-033 ld_en during ISSUE targeting R0 -> R0 unchanged; ld_en with accept in IDLE to R1=7 and op=011 ra=1 -> alu_A=7.
